// File: rtl/axi_lite_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axi_lite_regfile                                           |
// | Description : AXI4-Lite slave with NUM_REGS byte-strobed RW registers,   |
// |               per-register write pulses and SLVERR on unmapped indices.  |
// |               AXI_LITE_REGFILE_STATUS_EN adds a read-only status window. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axi_lite_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int NUM_STATUS = 4
) (
    input  logic                           i_axi_clk,
    input  logic                           i_axi_rst,
    input  logic                           i_awvalid,
    input  logic [ADDR_WIDTH-1:0]          i_awaddr,
    output logic                           o_awready,
    input  logic                           i_wvalid,
    output logic                           o_wready,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    output logic                           o_bvalid,
    input  logic                           i_bready,
    output logic [1:0]                     o_bresp,
    input  logic                           i_arvalid,
    output logic                           o_arready,
    input  logic [ADDR_WIDTH-1:0]          i_araddr,
    output logic                           o_rvalid,
    input  logic                           i_rready,
    output logic [1:0]                     o_rresp,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_wr_stb
`ifdef AXI_LITE_REGFILE_STATUS_EN
    ,
    input  logic [NUM_STATUS*DATA_WIDTH-1:0] i_status
`endif
);

    localparam int         c_STRB_W      = DATA_WIDTH / 8;
    localparam int         c_LSB         = $clog2(c_STRB_W);
    localparam int         c_IDX_W       = ADDR_WIDTH - c_LSB;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [c_IDX_W-1:0]    r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_W-1:0]   r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic [NUM_REGS-1:0]   r_wr_stb;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_wr_in_range;
    logic [NUM_REGS-1:0]   w_wr_hit;
    logic [c_IDX_W-1:0]    w_ar_idx;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_unused_bits;

    assign o_awready     = !r_aw_held && !r_bvalid && !i_axi_rst;
    assign o_wready      = !r_w_held && !r_bvalid && !i_axi_rst;
    assign o_arready     = !r_rvalid && !i_axi_rst;
    assign w_aw_hs       = i_awvalid && o_awready;
    assign w_w_hs        = i_wvalid && o_wready;
    assign w_ar_hs       = i_arvalid && o_arready;
    assign w_commit      = r_aw_held && r_w_held;
    assign w_wr_in_range = r_aw_idx < c_IDX_W'(NUM_REGS);
    assign w_ar_idx      = i_araddr[ADDR_WIDTH-1:c_LSB];

    // Byte-offset bits inside a word carry no meaning for this slave.
`ifdef AXI_LITE_REGFILE_STATUS_EN
    assign w_unused_bits = ^{i_awaddr[c_LSB-1:0], i_araddr[c_LSB-1:0]};
`else
    assign w_unused_bits = ^{i_awaddr[c_LSB-1:0], i_araddr[c_LSB-1:0], NUM_STATUS[0]};
`endif

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
            assign w_wr_hit[k] = (r_aw_idx == c_IDX_W'(k));
            assign o_regs[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
        end
    endgenerate

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_wr_stb  <= '0;
        end else begin
            r_wr_stb <= w_commit ? w_wr_hit : '0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= i_awaddr[ADDR_WIDTH-1:c_LSB];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
            // Readies are low while a response is pending, so no new capture can race the commit.
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
            end else if (r_bvalid && i_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < c_STRB_W; b++) begin
                    if (w_wr_hit[k] && r_wstrb[b]) begin
                        r_regs[k][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = c_RESP_SLVERR;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_ar_idx == c_IDX_W'(k)) begin
                w_rd_data = r_regs[k];
                w_rd_resp = c_RESP_OKAY;
            end
        end
`ifdef AXI_LITE_REGFILE_STATUS_EN
        for (int s = 0; s < NUM_STATUS; s++) begin
            if (w_ar_idx == c_IDX_W'(NUM_REGS + s)) begin
                w_rd_data = i_status[s*DATA_WIDTH +: DATA_WIDTH];
                w_rd_resp = c_RESP_OKAY;
            end
        end
`endif
    end

    // Read data is captured on the AR edge, so a same-edge write is not visible.
    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_wr_stb = r_wr_stb;
    assign o_rvalid = r_rvalid;
    assign o_rresp  = r_rresp;
    assign o_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axi_lite_regfile                                        |
// | Description : Randomised self-checking bench for axi_lite_regfile.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axi_lite_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0]   wr_stb;
`ifdef AXI_LITE_REGFILE_STATUS_EN
    logic [NS*DW-1:0] status = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'hCAFE_0001};
`endif

    logic [DW-1:0] model [NR];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_STATUS(NS)) dut (
        .i_axi_clk(clk), .i_axi_rst(rst),
        .i_awvalid(awvalid), .i_awaddr(awaddr), .o_awready(awready),
        .i_wvalid(wvalid), .o_wready(wready), .i_wstrb(wstrb), .i_wdata(wdata),
        .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
        .o_rvalid(rvalid), .i_rready(rready), .o_rresp(rresp), .o_rdata(rdata),
        .o_regs(regs), .o_wr_stb(wr_stb)
`ifdef AXI_LITE_REGFILE_STATUS_EN
        , .i_status(status)
`endif
    );

    task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = model[k];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int idx;
        bit aw_done, w_done, hs_aw, hs_w;
        logic [1:0] exp_resp;
        logic [NR-1:0] exp_stb;
        idx      = int'(addr >> 2);
        exp_resp = (idx < NR) ? 2'b00 : 2'b10;
        exp_stb  = (idx < NR) ? (NR'(1) << idx) : '0;
        aw_done  = 0;
        w_done   = 0;
        awaddr   = addr;
        wdata    = data;
        wstrb    = strb;
        for (int cyc = 0; cyc < 50 && !(aw_done && w_done); cyc++) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            hs_aw   = awvalid && awready;
            hs_w    = wvalid && wready;
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            return;
        end
        check("bvalid_not_early", bvalid, 0);
        tick();
        if (idx < NR)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        check("bvalid", bvalid, 1);
        check("bresp", bresp, exp_resp);
        check("wr_stb", wr_stb, exp_stb);
        check("regs_after_write", regs, model_flat());
        for (int i = 0; i < b_dly; i++) begin
            tick();
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp_resp);
            check("awready_blocked", {awready, wready}, 2'b00);
            check("wr_stb_single", wr_stb, 0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
        check("awready_back", {awready, wready}, 2'b11);
    endtask

    task automatic expect_read(input int idx, output logic [DW-1:0] d, output logic [1:0] r);
        d = '0;
        r = 2'b10;
        if (idx < NR) begin
            d = model[idx];
            r = 2'b00;
        end
`ifdef AXI_LITE_REGFILE_STATUS_EN
        else if (idx < NR + NS) begin
            d = status[(idx-NR)*DW +: DW];
            r = 2'b00;
        end
`endif
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int r_dly);
        bit hs;
        logic [DW-1:0] exp_d;
        logic [1:0] exp_r;
        expect_read(int'(addr >> 2), exp_d, exp_r);
        araddr  = addr;
        arvalid = 1'b1;
        hs      = 0;
        for (int cyc = 0; cyc < 50 && !hs; cyc++) begin
            hs = arready;
            tick();
        end
        arvalid = 1'b0;
        if (!hs) begin
            check("rd_handshake_timeout", 0, 1);
            return;
        end
        check("rvalid", rvalid, 1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, exp_d);
            check("arready_blocked", arready, 0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
        check("arready_back", arready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] old2;
        for (int k = 0; k < NR; k++) model[k] = '0;

        // Reset behaviour
        repeat (3) tick();
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_outputs", {bvalid, rvalid, bresp, rresp, wr_stb}, '0);
        check("rst_rdata", rdata, 0);
        check("rst_regs", regs, 0);
        rst = 1'b0;
        #1;
        check("post_rst_readies", {awready, wready, arready}, 3'b111);
        for (int k = 0; k < NR; k++) do_read(AW'(k*4), 0);

        // W leads AW by 3 cycles
        do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
        check("reg1_full", regs[DW +: DW], 32'hDEAD_BEEF);
        // Partial strobe
        do_write(32'h4, 32'h1122_3344, 4'h5, 0, 1, 0);
        check("reg1_partial", regs[DW +: DW], 32'hDE22_BE44);
        // Out of range / status window
        do_write(AW'(NR*4), 32'h5555_AAAA, 4'hF, 0, 0, 0);
        do_read(AW'(NR*4), 0);
        do_read(AW'(NR*4 + 44), 0);
        // Backpressure
        do_write(32'h8, 32'hAAAA_5555, 4'hF, 1, 0, 5);
        do_read(32'h8, 5);

        // Read and write to reg2 committing on the same edge
        old2 = model[2];
        check("simul_idle", {awready, wready, arready}, 3'b111);
        awaddr = 32'h8; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h8; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        model[2] = 32'h1234_5678;
        check("simul_rvalid", {rvalid, bvalid}, 2'b11);
        check("simul_rdata_old", rdata, old2);
        check("simul_regs_new", regs, model_flat());
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check("simul_clear", {rvalid, bvalid}, 2'b00);

        // Randomised traffic
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] a;
            a = AW'(($urandom_range(0, NR + 5) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        // Reset in the middle of a write aborts it
        awaddr = 32'h0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst = 1'b1; wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        tick();
        check("midrst_readies", {awready, wready, arready}, 3'b000);
        rst = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = '0;
        tick();
        check("midrst_no_resp", {bvalid, wr_stb}, 0);
        check("midrst_regs", regs, model_flat());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
